// File: rtl/fp_addsub_if.sv
// Request/response bundle between the fpu issue/writeback logic and fp_addsub.
// The master drives operands and start; the slave returns status and results.
interface fp_addsub_if #(
  parameter int unsigned FLEN = 32
);
  logic            start;
  logic            op;
  logic [FLEN-1:0] a;
  logic [FLEN-1:0] b;
  logic [2:0]      rm;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [FLEN-1:0] result;
  logic [4:0]      rd_out;
  logic [4:0]      flags;

  modport master (
    output start, op, a, b, rm, rd_in,
    input  busy, done, result, rd_out, flags
  );

  modport slave (
    input  start, op, a, b, rm, rd_in,
    output busy, done, result, rd_out, flags
  );
endinterface

// File: rtl/fp_addsub.sv
// Multi-cycle single-precision add/subtract: ALIGN, ADD, NORM, ROUND, DONE.
// Subnormals flush to zero; every operation takes five cycles from accept to done.
module fp_addsub #(
  parameter int unsigned FLEN = 32
) (
  input logic        clk,
  input logic        resetn,
  fp_addsub_if.slave bus
);
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam logic [4:0]  FL_NV  = 5'b10000;
  localparam logic [2:0]  RM_RTZ = 3'b001;
  localparam logic [2:0]  RM_RDN = 3'b010;
  localparam logic [2:0]  RM_RUP = 3'b011;
  localparam logic [2:0]  RM_RMM = 3'b100;

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_e;

  state_e state_q, state_d;
  logic   accept;

  logic [FLEN-1:0]   a_q, b_q, result_q;
  logic [2:0]        rm_q;
  logic [4:0]        rd_q, rd_out_q, flags_q;
  logic              spec_q, sign_q, sub_q, zero_q;
  logic [31:0]       spec_res_q;
  logic [4:0]        spec_flags_q;
  logic signed [9:0] exp_q;
  logic [26:0]       big_q, sml_q, man_q;
  logic [27:0]       sum_q;

  // ALIGN combinational signals
  logic [7:0]  ea, eb, e_big, e_sml, diff;
  logic [23:0] ma, mb, m_big, m_sml;
  logic [26:0] sml_ext, sml_sh, sml_al;
  logic        swap, s_big, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic        spec_d;
  logic [31:0] spec_res_d;
  logic [4:0]  spec_flags_d;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    ma     = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    mb     = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    a_snan = a_nan && !a_q[22];
    b_snan = b_nan && !b_q[22];
    a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    swap   = {eb, mb} > {ea, ma};
    e_big  = swap ? eb : ea;
    e_sml  = swap ? ea : eb;
    m_big  = swap ? mb : ma;
    m_sml  = swap ? ma : mb;
    s_big  = swap ? b_q[31] : a_q[31];
    diff   = e_big - e_sml;
    sml_ext = {m_sml, 3'b000};
    sml_sh  = sml_ext >> diff;
    if (diff > 8'd26) begin
      sml_al = {26'd0, |m_sml};
    end else begin
      sml_al = {sml_sh[26:1], sml_sh[0] | (|(sml_ext & ((27'd1 << diff) - 27'd1)))};
    end

    spec_d       = 1'b1;
    spec_res_d   = QNAN;
    spec_flags_d = 5'd0;
    if (rm_q > RM_RMM) begin
      spec_flags_d = FL_NV;
    end else if (a_nan || b_nan) begin
      spec_flags_d = (a_snan || b_snan) ? FL_NV : 5'd0;
    end else if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
      spec_flags_d = FL_NV;
    end else if (a_inf) begin
      spec_res_d = {a_q[31], 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_res_d = {b_q[31], 8'hFF, 23'd0};
    end else begin
      spec_d = 1'b0;
    end
  end

  // NORM combinational signals
  logic [4:0]        lzc;
  logic              lz_found;
  logic [26:0]       norm_man;
  logic signed [9:0] norm_exp;

  always_comb begin
    lzc      = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && sum_q[i]) begin
        lzc      = 5'(26 - i);
        lz_found = 1'b1;
      end
    end
    if (sum_q[27]) begin
      norm_man = {sum_q[27:2], sum_q[1] | sum_q[0]};
      norm_exp = exp_q + 10'sd1;
    end else begin
      norm_man = sum_q[26:0] << lzc;
      norm_exp = exp_q - $signed({5'd0, lzc});
    end
  end

  // ROUND combinational signals
  logic              inexact, inc;
  logic [24:0]       rnd;
  logic [23:0]       mant;
  logic signed [9:0] exp_r;
  logic [31:0]       res_d, max_fin, inf_val;
  logic [4:0]        flags_d;

  always_comb begin
    inexact = man_q[2] | man_q[1] | man_q[0];
    case (rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = inexact & sign_q;
      RM_RUP:  inc = inexact & ~sign_q;
      RM_RMM:  inc = man_q[2];
      default: inc = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    endcase
    rnd = {1'b0, man_q[26:3]} + {24'd0, inc};
    if (rnd[24]) begin
      mant  = rnd[24:1];
      exp_r = exp_q + 10'sd1;
    end else begin
      mant  = rnd[23:0];
      exp_r = exp_q;
    end
    max_fin = {sign_q, 31'h7F7F_FFFF};
    inf_val = {sign_q, 31'h7F80_0000};

    res_d   = {sign_q, exp_r[7:0], mant[22:0]};
    flags_d = {4'd0, inexact};
    if (spec_q) begin
      res_d   = spec_res_q;
      flags_d = spec_flags_q;
    end else if (zero_q) begin
      // Cancellation gives +0 except under RDN; like-signed zeros keep their sign.
      res_d   = {sub_q ? (rm_q == RM_RDN) : sign_q, 31'd0};
      flags_d = 5'd0;
    end else if (exp_q <= 10'sd0) begin
      res_d   = {sign_q, 31'd0};
      flags_d = 5'b00011;
    end else if (exp_r >= 10'sd255) begin
      flags_d = 5'b00101;
      case (rm_q)
        RM_RTZ:  res_d = max_fin;
        RM_RDN:  res_d = sign_q ? inf_val : max_fin;
        RM_RUP:  res_d = sign_q ? max_fin : inf_val;
        default: res_d = inf_val;
      endcase
    end
  end

  assign accept = bus.start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StRound;
      StRound: state_d = StDone;
      StDone:  state_d = accept ? StAlign : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      rm_q         <= '0;
      rd_q         <= '0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
      sign_q       <= 1'b0;
      sub_q        <= 1'b0;
      zero_q       <= 1'b0;
      exp_q        <= '0;
      big_q        <= '0;
      sml_q        <= '0;
      sum_q        <= '0;
      man_q        <= '0;
      result_q     <= '0;
      rd_out_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= bus.a;
        b_q  <= {bus.b[FLEN-1] ^ bus.op, bus.b[FLEN-2:0]};
        rm_q <= bus.rm;
        rd_q <= bus.rd_in;
      end
      unique case (state_q)
        StAlign: begin
          spec_q       <= spec_d;
          spec_res_q   <= spec_res_d;
          spec_flags_q <= spec_flags_d;
          sign_q       <= s_big;
          sub_q        <= a_q[31] ^ b_q[31];
          exp_q        <= $signed({2'b00, e_big});
          big_q        <= {m_big, 3'b000};
          sml_q        <= sml_al;
        end
        StAdd: sum_q <= sub_q ? {1'b0, big_q} - {1'b0, sml_q} : {1'b0, big_q} + {1'b0, sml_q};
        StNorm: begin
          man_q  <= norm_man;
          exp_q  <= norm_exp;
          zero_q <= (sum_q == 28'd0);
        end
        StRound: begin
          result_q <= res_d;
          flags_q  <= flags_d;
          rd_out_q <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q == StAlign) || (state_q == StAdd) ||
                      (state_q == StNorm)  || (state_q == StRound);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
  assign bus.flags  = flags_q;
endmodule

// File: tb/tb_fp_addsub.sv
// Directed bench for fp_addsub: a vector table of hand-computed results plus
// sequences for reset abort, dropped start while busy and back-to-back issue.
module tb_fp_addsub;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_if #(.FLEN(32)) bus ();
  fp_addsub #(.FLEN(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [2:0]  rm;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [2:0] rm, input logic [4:0] rd,
                         input logic [31:0] res, input logic [4:0] flg);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.rm = rm; v.rd = rd; v.res = res; v.flg = flg;
    vecs.push_back(v);
  endtask

  // Issue one operation and wait (bounded) for done; cyc=5 means done in the 5th cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [2:0] rm, input logic [4:0] rd,
                        output logic [31:0] res, output logic [4:0] flg,
                        output logic [4:0] rdo, output int cyc, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.op = op; bus.rm = rm; bus.rd_in = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (!bus.done && cyc < 12) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    res = bus.result;
    flg = bus.flags;
    rdo = bus.rd_out;
  endtask

  logic [31:0] r;
  logic [4:0]  f, rdo;
  int          cyc, bcnt, ndone, last;

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.rm = '0; bus.rd_in = '0;

    add_vec(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 5'd7,  32'h40400000, 5'b00000);
    add_vec(32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 5'd1,  32'h00000000, 5'b00000);
    add_vec(32'h3F800000, 32'h3F800000, 1'b1, 3'b010, 5'd2,  32'h80000000, 5'b00000);
    add_vec(32'h7F800000, 32'hFF800000, 1'b0, 3'b000, 5'd3,  32'h7FC00000, 5'b10000);
    add_vec(32'h7F800001, 32'h3F800000, 1'b0, 3'b000, 5'd4,  32'h7FC00000, 5'b10000);
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b000, 5'd5,  32'h7F800000, 5'b00101);
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b001, 5'd6,  32'h7F7FFFFF, 5'b00101);
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b010, 5'd8,  32'h7F7FFFFF, 5'b00101);
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b011, 5'd9,  32'h7F800000, 5'b00101);
    add_vec(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'b010, 5'd10, 32'hFF800000, 5'b00101);
    add_vec(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'b011, 5'd11, 32'hFF7FFFFF, 5'b00101);
    add_vec(32'h3F800000, 32'h33800000, 1'b0, 3'b000, 5'd12, 32'h3F800000, 5'b00001);
    add_vec(32'h3F800000, 32'h33800000, 1'b0, 3'b011, 5'd13, 32'h3F800001, 5'b00001);
    add_vec(32'h3F800000, 32'h33800000, 1'b0, 3'b100, 5'd14, 32'h3F800001, 5'b00001);
    add_vec(32'h3F800000, 32'h33800000, 1'b0, 3'b001, 5'd15, 32'h3F800000, 5'b00001);
    add_vec(32'h3F800000, 32'h33C00000, 1'b0, 3'b000, 5'd16, 32'h3F800001, 5'b00001);
    add_vec(32'h3F800000, 32'h3F800000, 1'b0, 3'b101, 5'd17, 32'h7FC00000, 5'b10000);
    add_vec(32'h7FC00000, 32'h3F800000, 1'b0, 3'b000, 5'd18, 32'h7FC00000, 5'b00000);
    add_vec(32'hFF800000, 32'h3F800000, 1'b1, 3'b000, 5'd19, 32'hFF800000, 5'b00000);
    add_vec(32'h3F800000, 32'h7F800000, 1'b1, 3'b000, 5'd20, 32'hFF800000, 5'b00000);
    add_vec(32'h00800000, 32'h00800001, 1'b1, 3'b000, 5'd21, 32'h80000000, 5'b00011);
    add_vec(32'h00000001, 32'h3F800000, 1'b0, 3'b000, 5'd22, 32'h3F800000, 5'b00000);
    add_vec(32'h40000000, 32'h3FC00000, 1'b1, 3'b000, 5'd23, 32'h3F000000, 5'b00000);
    add_vec(32'h80000000, 32'h80000000, 1'b0, 3'b000, 5'd24, 32'h80000000, 5'b00000);

    #12;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset flags", {27'd0, bus.flags}, 32'd0);
    check("reset rd_out", {27'd0, bus.rd_out}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rm, vecs[i].rd, r, f, rdo, cyc, bcnt);
      check($sformatf("v%0d latency", i), cyc, 32'd5);
      check($sformatf("v%0d result", i), r, vecs[i].res);
      check($sformatf("v%0d flags", i), {27'd0, f}, {27'd0, vecs[i].flg});
      check($sformatf("v%0d rd_out", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
      if (i == 0) check("busy cycles", bcnt, 32'd4);
    end

    // Reset asserted while the operation sits in NORM.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0;
    bus.rm = 3'b000; bus.rd_in = 5'd30;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy in norm", {31'd0, bus.busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort result", bus.result, 32'd0);
    check("abort flags", {27'd0, bus.flags}, 32'd0);
    check("abort rd_out", {27'd0, bus.rd_out}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("no done after abort", ndone, 32'd0);
    run_op(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 5'd7, r, f, rdo, cyc, bcnt);
    check("post-reset latency", cyc, 32'd5);
    check("post-reset result", r, 32'h40400000);
    check("post-reset rd_out", {27'd0, rdo}, 32'd7);

    // Start pulsed while busy is dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0;
    bus.rm = 3'b000; bus.rd_in = 5'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h40000000; bus.b = 32'h40000000; bus.rd_in = 5'd12;
    @(posedge clk); #1; bus.start = 1'b0;
    cyc = 2;
    while (!bus.done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drop latency", cyc, 32'd5);
    check("drop result", bus.result, 32'h40400000);
    check("drop rd_out", {27'd0, bus.rd_out}, 32'd3);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("no extra done", ndone, 32'd0);

    // Start held high: one result every 5 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0;
    bus.rm = 3'b000; bus.rd_in = 5'd5;
    ndone = 0;
    last = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        check("stream first/gap", k - last, (last < 0) ? 32'd5 : 32'd5);
        check("stream result", bus.result, 32'h40400000);
        last = k;
      end
    end
    bus.start = 1'b0;
    check("stream done count", ndone, 32'd4);
    repeat (6) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fp_addsub.md
Name: fp_addsub

Overview:
- Multi-cycle IEEE-754 single-precision add/subtract unit inside the fpu.
- Reads two operands from the f-register file and takes the rounding mode from fcsr[7:5].
- Returns the result, the destination index and the exception flags to the fpu writeback logic. That logic drives G, decodes rd_out into the one-hot F_in enable, and ORs flags into fcsr[4:0].
- Fixed latency for every case, single operation in flight.

Parameters:
- FLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; accepted only while busy=0
- op  in  1  0=a+b, 1=a-b
- a  in  FLEN  operand rs1
- b  in  FLEN  operand rs2
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- rd_in  in  5  destination register index, captured with operands
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result, flags and rd_out valid
- result  out  FLEN  rounded result
- rd_out  out  5  captured rd_in
- flags  out  5  fcsr bit order: [0] NX, [1] UF, [2] OF, [3] DZ, [4] NV

Behaviour:
- Reset: resetn=0 forces the following immediately, independent of clk:
  - state=IDLE
  - busy=0, done=0
  - result=0, rd_out=0, flags=0
  - all internal registers cleared
- Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- Acceptance: start=1 in IDLE or DONE on a rising edge captures a, b (b sign inverted if op=1), rm, rd_in, and goes to ALIGN.
- Sequence: ALIGN -> ADD -> NORM -> ROUND -> DONE, one state per clock, unconditional.
  - DONE -> IDLE, unless a new start is accepted, in which case DONE -> ALIGN.
- busy=1 in ALIGN, ADD, NORM, ROUND; busy=0 in IDLE and DONE. start while busy=1 is ignored, with no queuing.
- done=1 only in DONE, i.e. in the 5th cycle after the accepting edge. Back-to-back accepts give one result every 5 cycles.
- result, rd_out and flags update on entry to DONE and hold until the next DONE.
- ALIGN:
  - unpack sign, 8-bit exponent, 24-bit significand (implicit 1);
  - subnormal inputs (exp=0) are treated as signed zero, with no flag;
  - the smaller-exponent operand's significand is right-shifted by the exponent difference into a 27-bit guard/round/sticky field;
  - a difference >26 collapses the operand to sticky only.
- ADD:
  - 28-bit magnitude add when effective signs match, otherwise subtract the smaller magnitude from the larger;
  - the result sign is the larger operand's sign.
- NORM:
  - on carry-out, shift right 1 (OR the lost bit into sticky) and exponent+1;
  - otherwise left-shift by the leading-zero count, exponent-count.
- ROUND:
  - increment decision from guard, round+sticky, lsb, sign and rm;
  - RMM rounds ties away from zero;
  - significand rounding overflow renormalises, exponent+1;
  - NX when any discarded bit is non-zero.
- Overflow (exponent >=255 after rounding): OF|NX.
  - RNE and RMM return ±inf.
  - RTZ returns ±0x7F7FFFFF.
  - RDN returns +max-finite / -inf.
  - RUP returns +inf / -max-finite.
- Underflow (exponent <=0 after normalisation): result is signed zero, flags UF|NX (flush-to-zero).
- Exact zero sum of opposite-signed operands: +0, except RDN gives -0. Same-signed zeros keep their sign.
- Any NaN input: result 0x7FC00000. NV is set if either input is a signaling NaN (exp=255, frac!=0, frac[22]=0).
- Infinities:
  - inf - inf (effective) gives 0x7FC00000 with NV.
  - Otherwise an inf operand passes through with its effective sign, flags 0.
- rm in 101..111: result 0x7FC00000, flags NV only.
- DZ is always 0.
- Special cases still take the full 5-cycle latency.

Test Plan:
- 0x3F800000 + 0x40000000, op=0, RNE, rd_in=7 -> done 5 cycles after accept; result 0x40400000, flags 00000, rd_out=7; busy high for exactly 4 cycles.
- 0x3F800000 - 0x3F800000 (op=1), RNE -> 0x00000000 flags 0. Same with RDN -> 0x80000000 flags 0.
- 0x7F800000 + 0xFF800000, RNE -> 0x7FC00000, flags 10000. 0x7F800001 + 0x3F800000 -> 0x7FC00000, flags 10000.
- 0x7F7FFFFF + 0x7F7FFFFF:
  - RNE -> 0x7F800000, flags 00101;
  - RTZ -> 0x7F7FFFFF, flags 00101.
- 0x3F800000 + 0x33800000 (1 + 2^-24, exact tie):
  - RNE -> 0x3F800000, NX;
  - RUP -> 0x3F800001, NX;
  - RMM -> 0x3F800001, NX.
- Reset and flow control:
  - resetn pulsed low during NORM -> all outputs 0 immediately, no done pulse.
  - Next start completes normally.
  - start held high continuously -> done every 5 cycles. A start asserted while busy is dropped, so no extra done appears.
